prim_secded_39_32_stream_enc: RTL and testbench

// Multi-lane, pipelined SECDED (39,32) Hsiao encoder with valid/ready streaming and a beat counter.

---
 rtl/prim_secded_39_32_stream_enc.sv | 148 ++++++++++++++
 tb/tb_prim_secded_39_32_stream_enc.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_secded_39_32_stream_enc.sv
// Multi-lane SECDED (39,32) Hsiao encoder behind a single valid/ready register stage,
// with one-shot per-lane codeword error injection and a saturating accepted-beat counter.
module prim_secded_39_32_stream_enc #(
    parameter int unsigned NumLanes = 1,
    parameter int unsigned CntWidth = 16,
    localparam int unsigned LaneIdxW = (NumLanes > 1) ? $clog2(NumLanes) : 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [32*NumLanes-1:0]   in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [39*NumLanes-1:0]   out_data_o,
    input  logic                     inj_valid_i,
    input  logic [LaneIdxW-1:0]      inj_lane_i,
    input  logic [38:0]              inj_mask_i,
    output logic                     inj_armed_o,
    input  logic                     clr_cnt_i,
    output logic [CntWidth-1:0]      beat_cnt_o
);

    localparam int NumLanesI = int'(NumLanes);
    localparam int InW       = 32 * NumLanesI;
    localparam int OutW      = 39 * NumLanesI;

    if (NumLanes < 1 || NumLanes > 8) begin : g_bad_num_lanes
        $error("prim_secded_39_32_stream_enc: NumLanes must be in 1..8");
    end

    // Hsiao column masks; check bit j covers the data bits set in CheckMask[j].
    localparam logic [31:0] CheckMask [7] = '{
        32'h318D_C18C,
        32'hEA2A_B148,
        32'h8CC1_B6A1,
        32'h72C0_5A53,
        32'h4D12_083D,
        32'h047D_6456,
        32'h9336_0FA2
    };

    function automatic logic [6:0] calc_check(input logic [31:0] data);
        logic [6:0] chk;
        chk = '0;
        for (int j = 0; j < 7; j++) begin
            chk[j] = ^(data & CheckMask[j]);
        end
        return chk;
    endfunction

    logic                  out_valid_q, out_valid_d;
    logic [OutW-1:0]       out_data_q, out_data_d;
    logic                  inj_armed_q, inj_armed_d;
    logic [LaneIdxW-1:0]   inj_lane_q, inj_lane_d;
    logic [38:0]           inj_mask_q, inj_mask_d;
    logic [CntWidth-1:0]   beat_cnt_q, beat_cnt_d;

    logic                  accept;
    logic                  out_hs;
    logic                  inj_req_ok;
    logic [OutW-1:0]       enc_data;
    logic [OutW-1:0]       inj_vec;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign out_hs     = out_valid_q && out_ready_i;
    assign inj_req_ok = inj_valid_i && (32'(inj_lane_i) < NumLanes);

    always_comb begin
        enc_data = '0;
        inj_vec  = '0;
        for (int k = 0; k < NumLanesI; k++) begin
            enc_data[39*k +: 39] = {calc_check(in_data_i[32*k +: 32]), in_data_i[32*k +: 32]};
            if (inj_armed_q && (inj_lane_q == LaneIdxW'(k))) begin
                inj_vec[39*k +: 39] = inj_mask_q;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = enc_data ^ inj_vec;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    // The beat being accepted sees the old armed state; a coincident request arms for the next beat.
    always_comb begin
        inj_armed_d = inj_armed_q;
        inj_lane_d  = inj_lane_q;
        inj_mask_d  = inj_mask_q;
        if (accept) begin
            inj_armed_d = 1'b0;
        end
        if (inj_req_ok) begin
            inj_armed_d = 1'b1;
            inj_lane_d  = inj_lane_i;
            inj_mask_d  = inj_mask_i;
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (clr_cnt_i) begin
            beat_cnt_d = '0;
        end else if (accept && !(&beat_cnt_q)) begin
            beat_cnt_d = beat_cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            inj_armed_q <= 1'b0;
            inj_lane_q  <= '0;
            inj_mask_q  <= '0;
            beat_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            inj_armed_q <= inj_armed_d;
            inj_lane_q  <= inj_lane_d;
            inj_mask_q  <= inj_mask_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign inj_armed_o = inj_armed_q;
    assign beat_cnt_o  = beat_cnt_q;

    logic unused_in_width;
    assign unused_in_width = ^InW;

    a_stall_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_q && !out_ready_i) |=> (out_valid_q && $stable(out_data_q)));

    a_cnt_saturate: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((&beat_cnt_q) && !clr_cnt_i) |=> (&beat_cnt_q));

endmodule

// File: tb/tb_prim_secded_39_32_stream_enc.sv
// Directed bench for the three-lane SECDED stream encoder with a 4-bit beat counter;
// expected codewords are hand-computed constants.
module tb_prim_secded_39_32_stream_enc;

    localparam int NL = 3;
    localparam int CW = 4;

    logic              clk_i;
    logic              rst_ni;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [32*NL-1:0]  in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [39*NL-1:0]  out_data_o;
    logic              inj_valid_i;
    logic [1:0]        inj_lane_i;
    logic [38:0]       inj_mask_i;
    logic              inj_armed_o;
    logic              clr_cnt_i;
    logic [CW-1:0]     beat_cnt_o;

    int n_tests;
    int n_fail;

    prim_secded_39_32_stream_enc #(
        .NumLanes (NL),
        .CntWidth (CW)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .inj_valid_i (inj_valid_i),
        .inj_lane_i  (inj_lane_i),
        .inj_mask_i  (inj_mask_i),
        .inj_armed_o (inj_armed_o),
        .clr_cnt_i   (clr_cnt_i),
        .beat_cnt_o  (beat_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [38:0] lane(input int k);
        return out_data_o[39*k +: 39];
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst_ni      = 1'b0;
        in_valid_i  = 1'b0;
        in_data_i   = '0;
        out_ready_i = 1'b0;
        inj_valid_i = 1'b0;
        inj_lane_i  = '0;
        inj_mask_i  = '0;
        clr_cnt_i   = 1'b0;
        repeat (2) step();

        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_out_data",  64'(|out_data_o), 64'd0);
        chk("rst_armed",     64'(inj_armed_o), 64'd0);
        chk("rst_cnt",       64'(beat_cnt_o),  64'd0);
        chk("rst_in_ready",  64'(in_ready_o),  64'd1);
        rst_ni = 1'b1;
        step();

        // Single beat, three lanes.
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = {32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
        step();
        in_valid_i = 1'b0;
        chk("b1_valid", 64'(out_valid_o), 64'd1);
        chk("b1_lane0", 64'(lane(0)), 64'h1C_0000_0001);
        chk("b1_lane1", 64'(lane(1)), 64'h41_FFFF_FFFF);
        chk("b1_lane2", 64'(lane(2)), 64'h46_8000_0000);
        chk("b1_cnt",   64'(beat_cnt_o), 64'd1);
        step();
        chk("b1_drain", 64'(out_valid_o), 64'd0);

        in_valid_i = 1'b1;
        in_data_i  = {32'h0000_0000, 32'h0000_0003, 32'h0000_0002};
        step();
        in_valid_i = 1'b0;
        chk("b2_lane0", 64'(lane(0)), 64'h68_0000_0002);
        chk("b2_lane1", 64'(lane(1)), 64'h74_0000_0003);
        chk("b2_lane2", 64'(lane(2)), 64'h00_0000_0000);
        step();

        // Stall: downstream not ready for five cycles.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = {32'h0, 32'h0, 32'h0000_0001};
        step();
        in_data_i = {32'h0, 32'h0, 32'hFFFF_FFFF};
        chk("st_ready", 64'(in_ready_o), 64'd0);
        repeat (4) step();
        chk("st_valid", 64'(out_valid_o), 64'd1);
        chk("st_ready2", 64'(in_ready_o), 64'd0);
        chk("st_lane0", 64'(lane(0)), 64'h1C_0000_0001);
        chk("st_cnt",   64'(beat_cnt_o), 64'd3);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        chk("st_drain", 64'(out_valid_o), 64'd0);
        chk("st_cnt2",  64'(beat_cnt_o), 64'd3);

        // Back-to-back at full throughput.
        in_valid_i = 1'b1;
        in_data_i  = {32'h0, 32'h0, 32'h0000_0001};
        step();
        chk("bb_lane0a", 64'(lane(0)), 64'h1C_0000_0001);
        in_data_i = {32'h0, 32'h0, 32'hFFFF_FFFF};
        step();
        in_valid_i = 1'b0;
        chk("bb_valid",  64'(out_valid_o), 64'd1);
        chk("bb_lane0b", 64'(lane(0)), 64'h41_FFFF_FFFF);
        chk("bb_cnt",    64'(beat_cnt_o), 64'd5);
        step();

        // Arm lane 1 with mask 1, then an out-of-range request that must be dropped.
        inj_valid_i = 1'b1;
        inj_lane_i  = 2'd1;
        inj_mask_i  = 39'h1;
        step();
        chk("inj_armed", 64'(inj_armed_o), 64'd1);
        inj_lane_i = 2'd3;
        inj_mask_i = 39'h7F_FFFF_FFFF;
        step();
        inj_valid_i = 1'b0;
        chk("inj_drop_armed", 64'(inj_armed_o), 64'd1);
        in_valid_i = 1'b1;
        in_data_i  = '0;
        step();
        chk("inj_b1_lane1", 64'(lane(1)), 64'h1);
        chk("inj_b1_lane0", 64'(lane(0)), 64'h0);
        chk("inj_b1_lane2", 64'(lane(2)), 64'h0);
        chk("inj_consumed", 64'(inj_armed_o), 64'd0);
        step();
        chk("inj_b2_lane1", 64'(lane(1)), 64'h0);
        step();
        chk("inj_b3_lane1", 64'(lane(1)), 64'h0);
        chk("inj_cnt", 64'(beat_cnt_o), 64'd8);
        in_valid_i = 1'b0;
        step();

        // Re-arm without an accept: last request wins.
        inj_valid_i = 1'b1;
        inj_lane_i  = 2'd0;
        inj_mask_i  = 39'h0A;
        step();
        inj_lane_i = 2'd2;
        inj_mask_i = 39'h40_0000_0000;
        step();
        inj_valid_i = 1'b0;
        in_valid_i  = 1'b1;
        step();
        in_valid_i = 1'b0;
        chk("lw_lane2", 64'(lane(2)), 64'h40_0000_0000);
        chk("lw_lane0", 64'(lane(0)), 64'h0);
        chk("lw_armed", 64'(inj_armed_o), 64'd0);

        // Request coincident with an accept applies to the following beat.
        in_valid_i  = 1'b1;
        inj_valid_i = 1'b1;
        inj_lane_i  = 2'd0;
        inj_mask_i  = 39'h5;
        step();
        inj_valid_i = 1'b0;
        chk("co_clean", 64'(lane(0)), 64'h0);
        chk("co_armed", 64'(inj_armed_o), 64'd1);
        step();
        chk("co_corrupt", 64'(lane(0)), 64'h5);
        chk("co_disarm",  64'(inj_armed_o), 64'd0);
        in_valid_i = 1'b0;

        // Zero mask arms and consumes without corrupting.
        inj_valid_i = 1'b1;
        inj_lane_i  = 2'd1;
        inj_mask_i  = 39'h0;
        step();
        inj_valid_i = 1'b0;
        chk("z_armed", 64'(inj_armed_o), 64'd1);
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        chk("z_lane1", 64'(lane(1)), 64'h0);
        chk("z_disarm", 64'(inj_armed_o), 64'd0);
        chk("z_cnt", 64'(beat_cnt_o), 64'd12);

        // Counter saturation and clear priority.
        in_valid_i = 1'b1;
        repeat (2) step();
        chk("cnt_14", 64'(beat_cnt_o), 64'd14);
        repeat (6) step();
        chk("cnt_sat", 64'(beat_cnt_o), 64'hF);
        clr_cnt_i = 1'b1;
        step();
        clr_cnt_i = 1'b0;
        chk("cnt_clr", 64'(beat_cnt_o), 64'd0);
        chk("cnt_clr_valid", 64'(out_valid_o), 64'd1);
        step();
        in_valid_i = 1'b0;
        chk("cnt_after_clr", 64'(beat_cnt_o), 64'd1);

        // Asynchronous reset with a beat in flight and an injection armed.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = {32'h0, 32'h0, 32'h0000_0001};
        inj_valid_i = 1'b1;
        inj_lane_i  = 2'd2;
        inj_mask_i  = 39'h1;
        step();
        in_valid_i  = 1'b0;
        inj_valid_i = 1'b0;
        chk("pre_rst_valid", 64'(out_valid_o), 64'd1);
        chk("pre_rst_armed", 64'(inj_armed_o), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid_o), 64'd0);
        chk("ar_data",  64'(|out_data_o), 64'd0);
        chk("ar_armed", 64'(inj_armed_o), 64'd0);
        chk("ar_cnt",   64'(beat_cnt_o), 64'd0);
        step();
        rst_ni = 1'b1;
        step();
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        in_data_i   = '0;
        step();
        in_valid_i = 1'b0;
        chk("ar_lost_inj", 64'(lane(2)), 64'h0);
        chk("ar_cnt_post", 64'(beat_cnt_o), 64'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
